// File: rtl/dmem_burst_master_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_burst_master_if
// Purpose  : Bundles the command, read-stream, write-stream, memory-request
//            and status signals of dmem_burst_master.
// Modports :
//   master - the burst engine (drives cmd_ready, rd_*, wr_ready, mem_* requests,
//            busy/done/err)
//   slave  - the environment (drives commands, rd_ready, write data, mem_rdata)
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_burst_master_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) ();
  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;
  // read-data stream
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  // write-data stream
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  // memory request side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  cmd_valid, cmd_write, cmd_base, cmd_len,
    output cmd_ready,
    output rd_data, rd_valid,
    input  rd_ready,
    input  wr_data, wr_valid,
    output wr_ready,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_base, cmd_len,
    input  cmd_ready,
    input  rd_data, rd_valid,
    output rd_ready,
    output wr_data, wr_valid,
    input  wr_ready,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata,
    input  busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : dmem_burst_master
// Purpose  : Burst read/write engine. A command (base, len, write) is taken
//            in IDLE; reads stream memory words out through a one-entry
//            rd_data register with valid/ready backpressure, writes pass each
//            accepted wr_data word straight to memory in the same cycle.
// Ports    :
//   clk    - single clock, all state changes on posedge
//   reset  - asynchronous, active-high
//   bus    - dmem_burst_master_if.master (command, rd/wr streams, memory
//            request side, busy/done/err status)
// Options  : BURST_BOUNDS_CHECK_EN - when defined, commands whose last address
//            (base + len - 1) lies beyond MEM_TOP are accepted but rejected
//            with a one-cycle err pulse and no memory access. When undefined,
//            err is tied low and addresses simply wrap.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_burst_master #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int LEN_W   = 8,
  parameter int MEM_TOP = 1000
) (
  input  wire logic             clk,
  input  wire logic             reset,
  dmem_burst_master_if.master   bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_RD_DRAIN = 3'd2,
    ST_WR       = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_done;

  logic              w_accept;   // command handshake this cycle
  logic              w_reject;   // handshake of an out-of-range command
  logic              w_rd_load;  // a memory word is captured into r_rd_data
  logic              w_wr_fire;  // a write word is committed to memory
  logic              w_oob;      // command would run past MEM_TOP

`ifdef BURST_BOUNDS_CHECK_EN
  logic [ADDR_W:0]   w_last_addr;
  logic              r_err;

  // One extra bit so a burst running past the top of the address space is
  // seen as out of range instead of wrapping to a small address.
  assign w_last_addr = {1'b0, bus.cmd_base} + (ADDR_W+1)'(bus.cmd_len)
                       - (ADDR_W+1)'(1);
  assign w_oob       = (w_last_addr > (ADDR_W+1)'(MEM_TOP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_reject;
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_mem_top;

  assign w_oob            = 1'b0;
  assign w_unused_mem_top = (MEM_TOP != 0);
  assign bus.err          = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_rd_load   = 1'b0;
    w_wr_fire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_accept = 1'b1;
          // Zero length is checked first: base - 1 would otherwise be
          // judged against MEM_TOP for a burst that touches nothing.
          if (bus.cmd_len == '0) begin
            w_state_nxt = ST_DONE;
          end else if (w_oob) begin
            w_reject    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (bus.cmd_write) begin
            w_state_nxt = ST_WR;
          end else begin
            w_state_nxt = ST_RD;
          end
        end
      end
      ST_RD: begin
        // The output register can take a new word when it is empty or is
        // being emptied this same cycle.
        w_rd_load = !r_rd_valid || bus.rd_ready;
        if (w_rd_load && (r_rem == LEN_W'(1))) begin
          w_state_nxt = ST_RD_DRAIN;
        end
      end
      ST_RD_DRAIN: begin
        if (r_rd_valid && bus.rd_ready) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_WR: begin
        w_wr_fire = bus.wr_valid;
        if (w_wr_fire && (r_rem == LEN_W'(1))) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address pointer and remaining-word counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
      r_rem <= '0;
    end else if (w_accept) begin
      r_ptr <= bus.cmd_base;
      r_rem <= bus.cmd_len;
    end else if (w_rd_load || w_wr_fire) begin
      r_ptr <= r_ptr + ADDR_W'(1);   // natural modulo-2^ADDR_W wrap
      r_rem <= r_rem - LEN_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Read output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_rd_load) begin
      r_rd_data  <= bus.mem_rdata;
      r_rd_valid <= 1'b1;
    end else if (r_rd_valid && bus.rd_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Completion pulse: registered off the DONE state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.cmd_ready   = (r_state == ST_IDLE);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.rd_data     = r_rd_data;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.wr_ready    = (r_state == ST_WR);
  assign bus.mem_read    = (r_state == ST_RD);
  assign bus.mem_write   = w_wr_fire;
  // Address comes straight from a register, so it is stable for the whole
  // write cycle.
  assign bus.mem_address = r_ptr;
  assign bus.mem_wdata   = w_wr_fire ? bus.wr_data : '0;
  assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dmem_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_burst_master
// Purpose  : Directed self-checking bench for dmem_burst_master with a
//            64K-word memory model behind the memory request side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_burst_master;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   rd_cnt;
  int   wr_cnt;
  logic [15:0] mem [0:65535];

  dmem_burst_master_if #(.DATA_W(16), .ADDR_W(16), .LEN_W(8)) bus ();

  dmem_burst_master #(
    .DATA_W (16),
    .ADDR_W (16),
    .LEN_W  (8),
    .MEM_TOP(1000)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, write on posedge
  assign bus.mem_rdata = mem[bus.mem_address];

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_address] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.mem_read) begin
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one command; returns at the negedge after the handshake (+1).
  task automatic issue_cmd(input logic w, input logic [15:0] base, input logic [7:0] len);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    #1;
    chk_val("cmd_ready_at_issue", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_rd [4];
    int r0;
    int w0;

    n_vec  = 0;
    n_err  = 0;
    rd_cnt = 0;
    wr_cnt = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[100] = 16'd57; mem[101] = 16'd53; mem[102] = 16'd2; mem[103] = 16'd68;
    mem[0]   = 16'd10; mem[1]   = 16'd55; mem[2]   = 16'd28;
    for (int i = 300; i < 305; i++) mem[i] = 16'hAAAA;

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.rd_ready  = 1'b0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;

    // ---------------- reset state ----------------
    #2;
    chk_val("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk_val("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk_val("rst_rd_valid",  {31'd0, bus.rd_valid},  32'd0);
    chk_val("rst_rd_data",   {16'd0, bus.rd_data},   32'd0);
    chk_val("rst_mem_addr",  {16'd0, bus.mem_address}, 32'd0);
    chk_val("rst_mem_rw",    {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    chk_val("rst_done_err",  {30'd0, bus.done, bus.err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_val("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // ---------------- burst read, no backpressure ----------------
    exp_rd[0] = 16'd57; exp_rd[1] = 16'd53; exp_rd[2] = 16'd2; exp_rd[3] = 16'd68;
    bus.rd_ready = 1'b1;
    r0 = rd_cnt; w0 = wr_cnt;
    issue_cmd(1'b0, 16'd100, 8'd4);
    chk_val("rd_first_latency", {31'd0, bus.rd_valid}, 32'd0);
    chk_val("rd_mem_read",      {31'd0, bus.mem_read}, 32'd1);
    chk_val("rd_mem_addr",      {16'd0, bus.mem_address}, 32'd100);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_val("rd_valid", {31'd0, bus.rd_valid}, 32'd1);
      chk_val("rd_data",  {16'd0, bus.rd_data},  {16'd0, exp_rd[i]});
    end
    step();
    chk_val("rd_drained_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk_val("rd_done_early",    {31'd0, bus.done},     32'd0);
    step();
    chk_val("rd_done_pulse",    {31'd0, bus.done},     32'd1);
    step();
    chk_val("rd_done_clear",    {31'd0, bus.done},     32'd0);
    chk_val("rd_read_cycles",   32'(rd_cnt - r0),      32'd4);
    chk_val("rd_no_writes",     32'(wr_cnt - w0),      32'd0);

    // ---------------- read with backpressure ----------------
    bus.rd_ready = 1'b1;
    w0 = wr_cnt;
    issue_cmd(1'b0, 16'd0, 8'd3);
    step();
    chk_val("bp_first_data", {16'd0, bus.rd_data}, 32'd10);
    bus.rd_ready = 1'b0;
    step();
    chk_val("bp_hold1_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk_val("bp_hold1_data",  {16'd0, bus.rd_data},  32'd10);
    step();
    chk_val("bp_hold2_data",  {16'd0, bus.rd_data},  32'd10);
    bus.rd_ready = 1'b1;
    step();
    chk_val("bp_second_data", {16'd0, bus.rd_data},  32'd55);
    step();
    chk_val("bp_third_data",  {16'd0, bus.rd_data},  32'd28);
    chk_val("bp_third_valid", {31'd0, bus.rd_valid}, 32'd1);
    step();
    chk_val("bp_drained",     {31'd0, bus.rd_valid}, 32'd0);
    step();
    chk_val("bp_done_pulse",  {31'd0, bus.done},     32'd1);
    chk_val("bp_no_writes",   32'(wr_cnt - w0),      32'd0);

    // ---------------- burst write with a gap ----------------
    w0 = wr_cnt;
    issue_cmd(1'b1, 16'd200, 8'd2);
    bus.wr_data  = 16'd7;
    bus.wr_valid = 1'b1;
    #1;
    chk_val("wr_ready",      {31'd0, bus.wr_ready},  32'd1);
    chk_val("wr_mem_write",  {31'd0, bus.mem_write}, 32'd1);
    chk_val("wr_mem_addr0",  {16'd0, bus.mem_address}, 32'd200);
    chk_val("wr_mem_wdata0", {16'd0, bus.mem_wdata}, 32'd7);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    chk_val("wr_gap_no_write", {31'd0, bus.mem_write}, 32'd0);
    @(negedge clk);
    bus.wr_data  = 16'd9;
    bus.wr_valid = 1'b1;
    #1;
    chk_val("wr_mem_addr1",  {16'd0, bus.mem_address}, 32'd201);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    chk_val("wr_done_state_busy", {31'd0, bus.busy},     32'd1);
    chk_val("wr_done_state_wrdy", {31'd0, bus.wr_ready}, 32'd0);
    step();
    chk_val("wr_done_pulse", {31'd0, bus.done}, 32'd1);
    chk_val("wr_mem200",     {16'd0, mem[200]}, 32'd7);
    chk_val("wr_mem201",     {16'd0, mem[201]}, 32'd9);
    chk_val("wr_count",      32'(wr_cnt - w0),  32'd2);

    // ---------------- zero length ----------------
    r0 = rd_cnt; w0 = wr_cnt;
    issue_cmd(1'b1, 16'd50, 8'd0);
    chk_val("zl_busy",       {31'd0, bus.busy}, 32'd1);
    chk_val("zl_done_early", {31'd0, bus.done}, 32'd0);
    step();
    chk_val("zl_done_pulse", {31'd0, bus.done}, 32'd1);
    step();
    chk_val("zl_done_clear", {31'd0, bus.done}, 32'd0);
    chk_val("zl_no_access",  32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);

    // ---------------- reset during write ----------------
    w0 = wr_cnt;
    issue_cmd(1'b1, 16'd300, 8'd5);
    bus.wr_data  = 16'd1;
    bus.wr_valid = 1'b1;
    @(negedge clk);
    bus.wr_data  = 16'd2;
    @(negedge clk);
    bus.wr_data  = 16'd3;
    reset        = 1'b1;
    #1;
    chk_val("arst_busy",      {31'd0, bus.busy},      32'd0);
    chk_val("arst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk_val("arst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk_val("arst_mem_addr",  {16'd0, bus.mem_address}, 32'd0);
    chk_val("arst_rd_done",   {30'd0, bus.rd_valid, bus.done}, 32'd0);
    @(negedge clk);
    reset        = 1'b0;
    bus.wr_valid = 1'b0;
    #1;
    chk_val("arst_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    chk_val("arst_mem300",   {16'd0, mem[300]}, 32'd1);
    chk_val("arst_mem301",   {16'd0, mem[301]}, 32'd2);
    chk_val("arst_mem302",   {16'd0, mem[302]}, 32'h0000AAAA);
    chk_val("arst_wr_count", 32'(wr_cnt - w0),  32'd2);

`ifdef BURST_BOUNDS_CHECK_EN
    // ---------------- out-of-range command ----------------
    r0 = rd_cnt; w0 = wr_cnt;
    issue_cmd(1'b0, 16'd998, 8'd4);
    chk_val("oob_err_pulse", {31'd0, bus.err},  32'd1);
    chk_val("oob_idle",      {31'd0, bus.busy}, 32'd0);
    step();
    chk_val("oob_err_clear", {31'd0, bus.err},  32'd0);
    chk_val("oob_no_done1",  {31'd0, bus.done}, 32'd0);
    step();
    chk_val("oob_no_done2",  {31'd0, bus.done}, 32'd0);
    chk_val("oob_no_access", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
`else
    // ---------------- address wrap ----------------
    w0 = wr_cnt;
    issue_cmd(1'b1, 16'hFFFF, 8'd2);
    bus.wr_data  = 16'h1111;
    bus.wr_valid = 1'b1;
    #1;
    chk_val("wrap_addr0", {16'd0, bus.mem_address}, 32'h0000FFFF);
    @(negedge clk);
    bus.wr_data  = 16'h2222;
    #1;
    chk_val("wrap_addr1", {16'd0, bus.mem_address}, 32'd0);
    chk_val("wrap_err",   {31'd0, bus.err},         32'd0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    step();
    chk_val("wrap_done",    {31'd0, bus.done},   32'd1);
    chk_val("wrap_memFFFF", {16'd0, mem[65535]}, 32'h00001111);
    chk_val("wrap_mem0",    {16'd0, mem[0]},     32'h00002222);
    chk_val("wrap_count",   32'(wr_cnt - w0),    32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_burst_master.md
DMEM_BURST_MASTER -- requirements
Module: dmem_burst_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have parameter LEN_W, default 8, burst-length field width.
REQ-004 SHALL have parameter MEM_TOP, default 1000, highest valid memory address.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high.
REQ-008 cmd_write  in  1  1 = burst write, 0 = burst read; cmd_base  in  ADDR_W  start address; cmd_len  in  LEN_W  word count.
REQ-009 rd_data  out  DATA_W, rd_valid  out  1, rd_ready  in  1: read-data stream.
REQ-010 wr_data  in  DATA_W, wr_valid  in  1, wr_ready  out  1: write-data stream.
REQ-011 mem_read  out  1, mem_write  out  1, mem_address  out  ADDR_W, mem_wdata  out  DATA_W: memory request side.
REQ-012 mem_rdata  in  DATA_W: memory read data, combinationally valid for the current mem_address.
REQ-013 busy  out  1  high when not IDLE; done  out  1  one-cycle completion pulse; err  out  1  one-cycle reject pulse.

Function
REQ-014 SHALL implement states IDLE, RD, RD_DRAIN, WR, DONE.
REQ-015 cmd_ready SHALL equal (state == IDLE); a handshake latches base into ptr and len into remaining.
REQ-016 A handshake with cmd_len == 0 SHALL go directly to DONE with no memory access.
REQ-017 Otherwise IDLE SHALL go to WR if cmd_write, else to RD.
REQ-018 In RD, mem_read=1 and mem_address=ptr; when (!rd_valid || rd_ready), rd_data SHALL load mem_rdata, rd_valid SHALL set, ptr increments, remaining decrements.
REQ-019 RD SHALL go to RD_DRAIN when the last word is loaded; RD_DRAIN SHALL go to DONE on (rd_valid && rd_ready).
REQ-020 rd_valid SHALL clear on (rd_valid && rd_ready) when no new word loads in the same cycle; rd_data SHALL hold while (rd_valid && !rd_ready).
REQ-021 Read throughput SHALL be one word per cycle with rd_ready held high; first rd_valid SHALL appear one cycle after entering RD.
REQ-022 In WR, wr_ready SHALL be 1; on (wr_valid && wr_ready), mem_write=1, mem_address=ptr and mem_wdata=wr_data in that same cycle; ptr increments and remaining decrements.
REQ-023 WR SHALL go to DONE in the cycle after the last word is written.
REQ-024 mem_write SHALL be 0 outside WR and whenever wr_valid is low; mem_read SHALL be 0 outside RD.
REQ-025 ptr SHALL wrap modulo 2^ADDR_W (all-ones increments to 0).
REQ-026 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-027 The memory address SHALL never change within a write cycle; exactly one memory write SHALL occur per accepted write word.

Reset
REQ-028 Reset SHALL force IDLE, ptr=0, remaining=0, rd_valid=0, rd_data=0, done=0, err=0, busy=0, mem_read=0, mem_write=0, and mem_address=0, immediately and asynchronously.
REQ-029 Reset during a burst SHALL abandon it with no further memory write; after reset, cmd_ready SHALL be 1 in the first clock cycle.

Configuration
REQ-030 With BURST_BOUNDS_CHECK_EN defined, a command whose cmd_base + cmd_len - 1 exceeds MEM_TOP (computed at ADDR_W+1 bits) SHALL be accepted, produce no memory access, pulse err for one cycle, and return to IDLE without done.
REQ-031 Without BURST_BOUNDS_CHECK_EN, no check SHALL be made, err SHALL be tied to 0, and addresses SHALL wrap per REQ-025.

Verification
REQ-032 Burst read: base=100, len=4, rd_ready=1, memory[100..103] = 57,53,2,68 -> rd_data 57,53,2,68 on 4 consecutive cycles, then done pulse.
REQ-033 Read backpressure: base=0, len=3, rd_ready low for 2 cycles after the first valid -> rd_data=10 held stable, then 55,28 with no loss or duplication.
REQ-034 Burst write: base=200, len=2, wr_data 7 then 9 with wr_valid gapped by one idle cycle -> memory[200]=7, memory[201]=9, exactly 2 mem_write cycles, done.
REQ-035 Zero length: cmd_len=0 -> no mem_read or mem_write, done pulses 2 cycles after the handshake.
REQ-036 Reset during write: len=5, reset asserted after 2 words -> only 2 locations modified, all outputs at reset values, cmd_ready=1.
REQ-037 With BURST_BOUNDS_CHECK_EN: base=998, len=4 -> err pulse, no done, no memory access; without the macro: base=0xFFFF, len=2 -> writes to 0xFFFF then 0x0000.
